// File: rtl/spi_slave_rx.sv
// SPI slave receiver, fully synchronous to clk_in.
// SCLK, MOSI and CS_N are oversampled through synchroniser chains, and all
// decisions are made on the synchronised copies. Every received word is
// delivered as a one-cycle strobe. Frame start and frame end markers and a
// first-word flag let downstream parsers separate command bytes from payload.
module spi_slave_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  spi_sclk_in,
    input  logic                  spi_mosi_in,
    input  logic                  spi_cs_n_in,
    output logic                  data_rdy_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  first_word_out,
    output logic                  frame_start_out,
    output logic                  frame_end_out
);

    localparam logic IDLE_LVL    = (CPOL != 0);
    localparam logic SAMPLE_RISE = ((CPOL != 0) == (CPHA != 0));
    localparam int   CNT_W       = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_n_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_s;
    logic                   cs_n_s;
    logic                   mosi_s;

    logic                   sclk_d;
    logic                   cs_n_d;
    logic [SYNC_STAGES:0]   warm;
    logic                   warm_ok;
    logic                   sample_q;
    logic                   cs_fall_q;
    logic                   cs_rise_q;
    logic                   mosi_q;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  shift_reg;
    logic [DATA_WIDTH-1:0]  shift_next;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   first_flag;

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign cs_n_s  = cs_n_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign warm_ok = warm[SYNC_STAGES];

    // Synchroniser chains that bring the asynchronous SPI pins into the clk_in domain
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sclk_sync <= {SYNC_STAGES{IDLE_LVL}};
            cs_n_sync <= '1;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_in};
            cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], spi_cs_n_in};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_in};
        end
    end

    // Registered edge detection. MOSI is delayed alongside so the sampled bit
    // lines up with its edge pulse. Edges are ignored while warm-up is still
    // counting. During that time the chains hold reset values rather than pin
    // values, so a frame already in progress when reset is released is not
    // joined.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sclk_d    <= IDLE_LVL;
            cs_n_d    <= 1'b1;
            warm      <= '0;
            sample_q  <= 1'b0;
            cs_fall_q <= 1'b0;
            cs_rise_q <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            sclk_d    <= sclk_s;
            cs_n_d    <= cs_n_s;
            warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
            sample_q  <= warm_ok && (sclk_s != sclk_d) && (sclk_s == SAMPLE_RISE);
            cs_fall_q <= warm_ok && cs_n_d && !cs_n_s;
            cs_rise_q <= warm_ok && !cs_n_d && cs_n_s;
            mosi_q    <= mosi_s;
        end
    end

    // Next shift-register value, with the incoming bit entering according to bit order
    always_comb begin
        shift_next = shift_reg;
        if (MSB_FIRST != 0) begin
            shift_next = {shift_reg[DATA_WIDTH-2:0], mosi_q};
        end else begin
            shift_next = {mosi_q, shift_reg[DATA_WIDTH-1:1]};
        end
    end

    // Frame state machine: assembles words and drives the registered strobes
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= IDLE;
            shift_reg       <= '0;
            bit_cnt         <= '0;
            first_flag      <= 1'b0;
            data_out        <= '0;
            data_rdy_out    <= 1'b0;
            first_word_out  <= 1'b0;
            frame_start_out <= 1'b0;
            frame_end_out   <= 1'b0;
        end else begin
            data_rdy_out    <= 1'b0;
            frame_start_out <= 1'b0;
            frame_end_out   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall_q) begin
                        state           <= ACTIVE;
                        frame_start_out <= 1'b1;
                        bit_cnt         <= '0;
                        shift_reg       <= '0;
                        first_flag      <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cs_rise_q) begin
                        state         <= IDLE;
                        frame_end_out <= 1'b1;
                        bit_cnt       <= '0;
                    end else if (sample_q) begin
                        shift_reg <= shift_next;
                        if (bit_cnt == LAST_BIT) begin
                            data_out       <= shift_next;
                            data_rdy_out   <= 1'b1;
                            first_word_out <= first_flag;
                            first_flag     <= 1'b0;
                            bit_cnt        <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx.
// There are four 8-bit instances, one per SPI mode, and one 16-bit LSB-first
// instance. All instances share MOSI and CS_N. Modes 0/1 share one SCLK line
// and modes 2/3 share another. Because of this, a skewed MOSI pattern shows
// the correct-edge instance receiving the word while the opposite-edge
// instance receives its complement.
module tb_spi_slave_rx;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk0 = 1'b0;
    logic        sclk1 = 1'b1;
    logic        sclk2 = 1'b0;
    logic        mosi = 1'b0;
    logic        cs_n = 1'b1;

    logic [4:0]  rdy;
    logic [4:0]  first;
    logic [4:0]  fs;
    logic [4:0]  fe;
    logic [7:0]  data0, data1, data2, data3;
    logic [15:0] data16;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          edge_cyc = 0;

    int          rdy_cnt [5];
    int          fs_cnt [5];
    int          fe_cnt [5];
    bit          last_first [5];
    int          dbl_cnt = 0;
    logic [4:0]  rdy_prev = '0;
    logic [4:0]  fs_prev = '0;
    logic [4:0]  fe_prev = '0;
    logic [7:0]  q_data [$];
    bit          q_first [$];
    int          q_cyc [$];

    spi_slave_rx #(.DATA_WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) dut0 (
        .clk_in(clk_in), .rst_n_in(rst_n), .spi_sclk_in(sclk0), .spi_mosi_in(mosi),
        .spi_cs_n_in(cs_n), .data_rdy_out(rdy[0]), .data_out(data0),
        .first_word_out(first[0]), .frame_start_out(fs[0]), .frame_end_out(fe[0]));

    spi_slave_rx #(.DATA_WIDTH(8), .CPOL(0), .CPHA(1), .MSB_FIRST(1)) dut1 (
        .clk_in(clk_in), .rst_n_in(rst_n), .spi_sclk_in(sclk0), .spi_mosi_in(mosi),
        .spi_cs_n_in(cs_n), .data_rdy_out(rdy[1]), .data_out(data1),
        .first_word_out(first[1]), .frame_start_out(fs[1]), .frame_end_out(fe[1]));

    spi_slave_rx #(.DATA_WIDTH(8), .CPOL(1), .CPHA(0), .MSB_FIRST(1)) dut2 (
        .clk_in(clk_in), .rst_n_in(rst_n), .spi_sclk_in(sclk1), .spi_mosi_in(mosi),
        .spi_cs_n_in(cs_n), .data_rdy_out(rdy[2]), .data_out(data2),
        .first_word_out(first[2]), .frame_start_out(fs[2]), .frame_end_out(fe[2]));

    spi_slave_rx #(.DATA_WIDTH(8), .CPOL(1), .CPHA(1), .MSB_FIRST(1)) dut3 (
        .clk_in(clk_in), .rst_n_in(rst_n), .spi_sclk_in(sclk1), .spi_mosi_in(mosi),
        .spi_cs_n_in(cs_n), .data_rdy_out(rdy[3]), .data_out(data3),
        .first_word_out(first[3]), .frame_start_out(fs[3]), .frame_end_out(fe[3]));

    spi_slave_rx #(.DATA_WIDTH(16), .CPOL(0), .CPHA(0), .MSB_FIRST(0)) dut16 (
        .clk_in(clk_in), .rst_n_in(rst_n), .spi_sclk_in(sclk2), .spi_mosi_in(mosi),
        .spi_cs_n_in(cs_n), .data_rdy_out(rdy[4]), .data_out(data16),
        .first_word_out(first[4]), .frame_start_out(fs[4]), .frame_end_out(fe[4]));

    // 100 MHz system clock
    always #5 clk_in = ~clk_in;

    // Cycle counter used to timestamp sample edges and strobes
    always @(posedge clk_in) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge away from the active edge
    always @(negedge clk_in) begin
        for (int i = 0; i < 5; i++) begin
            if (rdy[i]) begin
                rdy_cnt[i]++;
                last_first[i] = first[i];
            end
            if (fs[i]) fs_cnt[i]++;
            if (fe[i]) fe_cnt[i]++;
            if ((rdy[i] && rdy_prev[i]) || (fs[i] && fs_prev[i]) || (fe[i] && fe_prev[i]))
                dbl_cnt++;
        end
        if (rdy[0]) begin
            q_data.push_back(data0);
            q_first.push_back(first[0]);
            q_cyc.push_back(cyc);
        end
        rdy_prev = rdy;
        fs_prev  = fs;
        fe_prev  = fe;
    end

    function automatic logic [31:0] qWord(input int idx);
        return (idx < q_data.size()) ? {24'd0, q_data[idx]} : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] qFirst(input int idx);
        return (idx < q_first.size()) ? {31'd0, q_first[idx]} : 32'hDEAD_BEEF;
    endfunction

    function automatic int qCyc(input int idx);
        return (idx < q_cyc.size()) ? q_cyc[idx] : -1000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setSclk(input int line, input logic v);
        case (line)
            0:       sclk0 = v;
            1:       sclk1 = v;
            default: sclk2 = v;
        endcase
    endtask

    // One SPI bit. MOSI is set to L around the leading edge and to T around the
    // trailing edge. With skew set, the edge that is not the sampling edge sees
    // the inverted bit.
    task automatic applyBit(input int line, input bit cpol, input bit cpha,
                            input logic b, input bit skew, input int half);
        logic lv, tv;
        lv = (cpha && skew) ? ~b : b;
        tv = (!cpha && skew) ? ~b : b;
        mosi = lv;
        #(half / 2);
        setSclk(line, ~cpol);
        if (!cpha) edge_cyc = cyc;
        #(half / 2);
        mosi = tv;
        #(half / 2);
        setSclk(line, cpol);
        if (cpha) edge_cyc = cyc;
        #(half / 2);
    endtask

    task automatic applyStimulus(input int line, input bit cpol, input bit cpha,
                                 input logic [31:0] word, input int nbits,
                                 input bit msb_first, input bit skew, input int half);
        logic [31:0] w;
        w = word;
        for (int k = 0; k < nbits; k++) begin
            applyBit(line, cpol, cpha, w[msb_first ? (nbits - 1 - k) : k], skew, half);
        end
    endtask

    task automatic csLow();
        cs_n = 1'b0;
        #80;
    endtask

    task automatic csHigh();
        #80;
        cs_n = 1'b1;
        #100;
    endtask

    initial begin
        int rb, fsb, feb, qb, lat_edge;
        logic [7:0] bytes [32];

        // Reset state, checked while reset is still asserted
        #2;
        checkOutput("rst_data0", {24'd0, data0}, 32'h0);
        checkOutput("rst_data16", {16'd0, data16}, 32'h0);
        checkOutput("rst_rdy", {27'd0, rdy}, 32'h0);
        checkOutput("rst_first", {27'd0, first}, 32'h0);
        checkOutput("rst_fs_fe", {22'd0, fs, fe}, 32'h0);
        #20;
        rst_n = 1'b1;
        #100;

        // Mode 0: one frame carrying 0xA5 then 0x3C
        rb = rdy_cnt[0]; fsb = fs_cnt[0]; feb = fe_cnt[0]; qb = q_data.size();
        csLow();
        applyStimulus(0, 0, 0, 32'hA5, 8, 1, 0, 40);
        lat_edge = edge_cyc;
        applyStimulus(0, 0, 0, 32'h3C, 8, 1, 0, 40);
        csHigh();
        checkOutput("m0_rdy_count", rdy_cnt[0] - rb, 2);
        checkOutput("m0_word0", qWord(qb), 32'hA5);
        checkOutput("m0_first0", qFirst(qb), 32'h1);
        checkOutput("m0_word1", qWord(qb + 1), 32'h3C);
        checkOutput("m0_first1", qFirst(qb + 1), 32'h0);
        checkOutput("m0_frame_start", fs_cnt[0] - fsb, 1);
        checkOutput("m0_frame_end", fe_cnt[0] - feb, 1);
        checkOutput("m0_latency", qCyc(qb) - lat_edge, 4);

        // Mode 1 with skewed MOSI: mode-1 instance sees 0x96, mode-0 instance its complement
        rb = rdy_cnt[1];
        csLow();
        applyStimulus(0, 0, 1, 32'h96, 8, 1, 1, 40);
        csHigh();
        checkOutput("m1_rdy_count", rdy_cnt[1] - rb, 1);
        checkOutput("m1_data", {24'd0, data1}, 32'h96);
        checkOutput("m1_first", {31'd0, last_first[1]}, 32'h1);
        checkOutput("m1_wrong_edge", {24'd0, data0}, 32'h69);

        // Mode 2 with skewed MOSI
        rb = rdy_cnt[2];
        csLow();
        applyStimulus(1, 1, 0, 32'h96, 8, 1, 1, 40);
        csHigh();
        checkOutput("m2_rdy_count", rdy_cnt[2] - rb, 1);
        checkOutput("m2_data", {24'd0, data2}, 32'h96);
        checkOutput("m2_wrong_edge", {24'd0, data3}, 32'h69);

        // Mode 3 with skewed MOSI
        rb = rdy_cnt[3];
        csLow();
        applyStimulus(1, 1, 1, 32'h96, 8, 1, 1, 40);
        csHigh();
        checkOutput("m3_rdy_count", rdy_cnt[3] - rb, 1);
        checkOutput("m3_data", {24'd0, data3}, 32'h96);
        checkOutput("m3_wrong_edge", {24'd0, data2}, 32'h69);

        // 16-bit LSB-first: no word after 15 edges, exactly one after the 16th
        rb = rdy_cnt[4];
        csLow();
        for (int k = 0; k < 15; k++) begin
            applyBit(2, 0, 0, ((16'h1234 >> k) & 16'h1) != 0, 0, 40);
        end
        #60;
        checkOutput("lsb_no_rdy_15", rdy_cnt[4] - rb, 0);
        applyBit(2, 0, 0, 1'b0, 0, 40);
        #60;
        checkOutput("lsb_rdy_16", rdy_cnt[4] - rb, 1);
        checkOutput("lsb_data", {16'd0, data16}, 32'h1234);
        csHigh();

        // Partial word discarded on CS release, then a fresh frame with 0xFF
        rb = rdy_cnt[0]; feb = fe_cnt[0];
        csLow();
        applyStimulus(0, 0, 0, 32'h15, 5, 1, 0, 40);
        csHigh();
        checkOutput("part_no_rdy", rdy_cnt[0] - rb, 0);
        checkOutput("part_data_hold", {24'd0, data0}, 32'h69);
        checkOutput("part_frame_end", fe_cnt[0] - feb, 1);
        csLow();
        applyStimulus(0, 0, 0, 32'hFF, 8, 1, 0, 40);
        csHigh();
        checkOutput("part_next_data", {24'd0, data0}, 32'hFF);
        checkOutput("part_next_first", {31'd0, last_first[0]}, 32'h1);
        checkOutput("part_next_count", rdy_cnt[0] - rb, 1);

        // Reset pulse mid-word with CS held low and SCLK still running
        rb = rdy_cnt[0]; fsb = fs_cnt[0]; feb = fe_cnt[0];
        csLow();
        applyStimulus(0, 0, 0, 32'h6, 3, 1, 0, 40);
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_data0", {24'd0, data0}, 32'h0);
        checkOutput("mrst_rdy_first", {30'd0, rdy[0], first[0]}, 32'h0);
        #9;
        applyBit(0, 0, 0, 1'b1, 0, 40);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 32'h1A5C, 13, 1, 0, 40);
        checkOutput("mrst_no_rdy", rdy_cnt[0] - rb, 0);
        checkOutput("mrst_no_restart", fs_cnt[0] - fsb, 1);
        csHigh();
        checkOutput("mrst_no_frame_end", fe_cnt[0] - feb, 0);
        csLow();
        applyStimulus(0, 0, 0, 32'h5A, 8, 1, 0, 40);
        csHigh();
        checkOutput("mrst_new_data", {24'd0, data0}, 32'h5A);
        checkOutput("mrst_new_first", {31'd0, last_first[0]}, 32'h1);

        // Maximum rate: SCLK = clk_in/4, 32 back-to-back bytes in one frame
        for (int i = 0; i < 32; i++) bytes[i] = 8'((i * 37 + 11) & 255);
        rb = rdy_cnt[0]; qb = q_data.size();
        csLow();
        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 0, 0, {24'd0, bytes[i]}, 8, 1, 0, 20);
        end
        csHigh();
        checkOutput("max_rdy_count", rdy_cnt[0] - rb, 32);
        checkOutput("max_first", qFirst(qb), 32'h1);
        for (int i = 0; i < 32; i++) begin
            checkOutput($sformatf("max_byte%0d", i), qWord(qb + i), {24'd0, bytes[i]});
            if (i > 0) begin
                checkOutput($sformatf("max_gap%0d", i), qCyc(qb + i) - qCyc(qb + i - 1), 32);
            end
        end

        checkOutput("no_double_pulse", dbl_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
Parametrised SPI slave receiver, fully synchronous to clk_in. It oversamples the SPI pins through synchroniser stages and supports all four CPOL/CPHA modes. Word width and bit order are configurable. It delivers each received word as a one-cycle strobe, with frame start/end markers and a first-word flag, so downstream command/pixel parsers can split command bytes from payload.

Parameters:
DATA_WIDTH, 8, bits per word (2..32)
SYNC_STAGES, 2, synchroniser flops per SPI input (>=2)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
MSB_FIRST, 1, 1 = first received bit lands in data_out[DATA_WIDTH-1]; 0 = in data_out[0]

Ports:
clk_in  input  1  system clock; must be >= 4x SCLK frequency
rst_n_in  input  1  reset, asynchronous, active-low
spi_sclk_in  input  1  SPI clock, asynchronous to clk_in
spi_mosi_in  input  1  SPI data in
spi_cs_n_in  input  1  SPI chip select, active-low
data_rdy_out  output  1  one-cycle pulse: data_out holds a new complete word
data_out  output  DATA_WIDTH  last complete word; holds until the next word
first_word_out  output  1  qualifies data_rdy_out: word is the first of the current frame
frame_start_out  output  1  one-cycle pulse on synchronised CS assertion
frame_end_out  output  1  one-cycle pulse on synchronised CS deassertion

Behaviour:
- Reset (async, rst_n_in low) values:
  - sync chains: sclk=CPOL, cs_n=1, mosi=0
  - shift register and data_out = 0
  - bit counter = 0
  - all pulse outputs = 0; first_word_out = 0
  - state IDLE
- Synchronisation: each SPI input passes SYNC_STAGES flops. An extra flop on sclk_s and cs_n_s provides edge detection. All logic uses the synchronised signals only.
- Sample edge: rising sclk_s when CPOL^CPHA==0, falling otherwise. The opposite edge is ignored; this is a receive-only block.
- States:
  - IDLE: cs_n_s high. cs_n_s falling -> ACTIVE. In the same cycle: frame_start_out=1, bit counter=0, shift register=0, internal first flag set.
  - ACTIVE: on each sample edge with cs_n_s low, shift mosi_s in. MSB_FIRST=1 shifts left with the new bit at LSB; MSB_FIRST=0 shifts right with the new bit at MSB. Bit counter increments.
  - ACTIVE, word completion: when a sample edge arrives with counter == DATA_WIDTH-1:
    - data_out is loaded with the completed word (shift register plus current bit) and data_rdy_out=1 in the next cycle
    - first_word_out = internal first flag
    - internal first flag then clears
    - counter wraps to 0
  - ACTIVE, CS release: cs_n_s rising -> IDLE. frame_end_out=1 for one cycle. A partial word is discarded with no data_rdy_out. Counter is cleared. data_out keeps its last complete word.
- Latency: pin sample edge -> data_rdy_out high = SYNC_STAGES+2 clk_in cycles (SYNC_STAGES sync + 1 edge-detect + 1 output register).
- Simultaneous events:
  - sclk_s sample edge in the same cycle as cs_n_s rising: the edge is ignored, and only the frame end is processed.
  - sclk_s edge in the same cycle as cs_n_s falling: the edge is ignored. Masters must keep >= 1 SCLK half-period of CS setup.
  - Back-to-back words: no gap required; data_rdy_out can pulse every DATA_WIDTH sample edges.
- Glitch tolerance: a CS pulse high for less than SYNC_STAGES cycles may be missed. This is allowed; no output requirement applies.
- Reset mid-frame: all state is returned to reset values immediately. After release, a frame in progress is not joined: the block stays in IDLE until cs_n_s is seen high and then falls again.
- Pulse outputs are registered and never high for two consecutive cycles for the same event.

Test Plan:
- Mode 0, DATA_WIDTH=8, MSB_FIRST=1: one frame sends 0xA5, 0x3C.
  -> frame_start once; two data_rdy pulses with data_out 0xA5 (first_word=1), then 0x3C (first_word=0); frame_end once.
- Modes 1, 2, 3, each with 0x96:
  -> data_out=0x96 in every mode. Sampling on the wrong edge must produce a mismatch (negative check with a deliberately skewed MOSI).
- MSB_FIRST=0, DATA_WIDTH=16: send bits of 0x1234 LSB first.
  -> data_out=0x1234 after exactly 16 sample edges.
- CS released after 5 bits, then a new frame sends 0xFF.
  -> no data_rdy for the partial word; data_out stays at its old value until the 0xFF word; first_word=1 for 0xFF.
- rst_n_in pulsed low mid-word, CS still low, SCLK running.
  -> outputs go to reset values asynchronously; no data_rdy until the next CS falling edge.
- Max rate, SCLK = clk_in/4, 32 back-to-back bytes.
  -> 32 data_rdy pulses, every byte correct, spacing = 32 clk_in cycles.
